// File: rtl/l2_port_arbiter_if.sv
// Bundle of the two requester ports and the shared L2 cache group command port.
// master = the arbiter itself, slave = the surrounding requesters and cache.
interface l2_port_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
);
  logic               p0_rreq;
  logic               p0_wreq;
  logic [ADDR_W-1:0]  p0_addr;
  logic [BURST_W-1:0] p0_burst;
  logic [DATA_W-1:0]  p0_wdata;
  logic [DATA_W-1:0]  p0_rdata;
  logic               p0_busy;
  logic               p0_done;
  logic               p1_rreq;
  logic               p1_wreq;
  logic [ADDR_W-1:0]  p1_addr;
  logic [BURST_W-1:0] p1_burst;
  logic [DATA_W-1:0]  p1_wdata;
  logic [DATA_W-1:0]  p1_rdata;
  logic               p1_busy;
  logic               p1_done;
  logic               c_rreq;
  logic               c_wreq;
  logic [ADDR_W-1:0]  c_addr;
  logic [BURST_W-1:0] c_burst;
  logic [DATA_W-1:0]  c_wdata;
  logic [DATA_W-1:0]  c_rdata;
  logic               c_busy;
  logic               timeout_err;

  modport master (
    input  p0_rreq, p0_wreq, p0_addr, p0_burst, p0_wdata,
    input  p1_rreq, p1_wreq, p1_addr, p1_burst, p1_wdata,
    input  c_rdata, c_busy,
    output p0_rdata, p0_busy, p0_done, p1_rdata, p1_busy, p1_done,
    output c_rreq, c_wreq, c_addr, c_burst, c_wdata, timeout_err
  );

  modport slave (
    output p0_rreq, p0_wreq, p0_addr, p0_burst, p0_wdata,
    output p1_rreq, p1_wreq, p1_addr, p1_burst, p1_wdata,
    output c_rdata, c_busy,
    input  p0_rdata, p0_busy, p0_done, p1_rdata, p1_busy, p1_done,
    input  c_rreq, c_wreq, c_addr, c_burst, c_wdata, timeout_err
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// Two-port round-robin arbiter in front of one L2 cache group command port.
// One request slot per port; the winner is replayed onto the cache and tracked through its busy window.
module l2_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5,
  parameter int DRAIN   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  l2_port_arbiter_if.master bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [DW-1:0] DRN_LAST = DW'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DRAIN     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         vld_q, wr_q, done_q, done_d, clr_s;
  logic [1:0]         rreq_s, wreq_s;
  logic [ADDR_W-1:0]  addr_q [2];
  logic [BURST_W-1:0] burst_q [2];
  logic [ADDR_W-1:0]  p_addr_s [2];
  logic [BURST_W-1:0] p_burst_s [2];
  logic               owner_q, owner_d, prio_q, prio_d, grant_s;
  logic [ADDR_W-1:0]  c_addr_q, c_addr_d;
  logic [BURST_W-1:0] c_burst_q, c_burst_d;
  logic               c_rreq_q, c_rreq_d, c_wreq_q, c_wreq_d;
  logic               terr_q, terr_d, own_act_s;
  logic [TW-1:0]      to_cnt_q, to_cnt_d, to_inc_s;
  logic [DW-1:0]      drn_cnt_q, drn_cnt_d;

  assign rreq_s       = {bus.p1_rreq, bus.p0_rreq};
  assign wreq_s       = {bus.p1_wreq, bus.p0_wreq};
  assign p_addr_s[0]  = bus.p0_addr;
  assign p_addr_s[1]  = bus.p1_addr;
  assign p_burst_s[0] = bus.p0_burst;
  assign p_burst_s[1] = bus.p1_burst;
  assign to_inc_s     = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);

  // Per-port request slots: capture while empty, release on the completion edge
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 2'b00;
      wr_q  <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        addr_q[n]  <= '0;
        burst_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (clr_s[n]) begin
          vld_q[n] <= 1'b0;
        end else if (!vld_q[n] && (rreq_s[n] || wreq_s[n])) begin
          vld_q[n]   <= 1'b1;
          wr_q[n]    <= !rreq_s[n];
          addr_q[n]  <= p_addr_s[n];
          burst_q[n] <= (p_burst_s[n] == '0) ? BURST_W'(1) : p_burst_s[n];
        end
      end
    end
  end

  // FSM state and registered cache/completion outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      c_addr_q  <= '0;
      c_burst_q <= '0;
      c_rreq_q  <= 1'b0;
      c_wreq_q  <= 1'b0;
      done_q    <= 2'b00;
      terr_q    <= 1'b0;
      to_cnt_q  <= '0;
      drn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      c_addr_q  <= c_addr_d;
      c_burst_q <= c_burst_d;
      c_rreq_q  <= c_rreq_d;
      c_wreq_q  <= c_wreq_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      to_cnt_q  <= to_cnt_d;
      drn_cnt_q <= drn_cnt_d;
    end
  end

  // Next-state logic: grant, issue, busy tracking with timeout, drain and completion
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    c_addr_d  = c_addr_q;
    c_burst_d = c_burst_q;
    c_rreq_d  = 1'b0;
    c_wreq_d  = 1'b0;
    terr_d    = terr_q;
    to_cnt_d  = to_cnt_q;
    drn_cnt_d = drn_cnt_q;
    grant_s   = 1'b0;
    done_d    = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (vld_q != 2'b00) begin
          // Both pending: the port that did not win last time goes first
          grant_s   = (vld_q == 2'b11) ? prio_q : vld_q[1];
          owner_d   = grant_s;
          c_addr_d  = addr_q[grant_s];
          c_burst_d = burst_q[grant_s];
          c_rreq_d  = !wr_q[grant_s];
          c_wreq_d  = wr_q[grant_s];
          state_d   = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        to_cnt_d = to_inc_s;
        if (to_inc_s == TO_MAX) begin
          terr_d    = 1'b1;
          drn_cnt_d = '0;
          state_d   = S_DRAIN;
        end else if ((state_q == S_WAIT_BUSY) && bus.c_busy) begin
          state_d = S_WAIT_DONE;
        end else if ((state_q == S_WAIT_DONE) && !bus.c_busy) begin
          drn_cnt_d = '0;
          state_d   = S_DRAIN;
        end else begin
          state_d = state_q;
        end
      end
      S_DRAIN: begin
        if (drn_cnt_q == DRN_LAST) begin
          prio_d  = !owner_q;
          owner_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          drn_cnt_d = drn_cnt_q + DW'(1);
          state_d   = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // done and busy-release land together on the edge into the last drain cycle
    if ((state_d == S_DRAIN) && (drn_cnt_d == DRN_LAST)) begin
      done_d = owner_q ? 2'b10 : 2'b01;
    end else begin
      done_d = 2'b00;
    end
  end

  assign clr_s     = done_d;
  assign own_act_s = (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE) || (state_q == S_DRAIN);

  assign bus.p0_rdata    = (own_act_s && !owner_q) ? bus.c_rdata : '0;
  assign bus.p1_rdata    = (own_act_s && owner_q) ? bus.c_rdata : '0;
  assign bus.c_wdata     = (state_q == S_IDLE) ? '0 : (owner_q ? bus.p1_wdata : bus.p0_wdata);
  assign bus.p0_busy     = vld_q[0];
  assign bus.p1_busy     = vld_q[1];
  assign bus.p0_done     = done_q[0];
  assign bus.p1_done     = done_q[1];
  assign bus.c_rreq      = c_rreq_q;
  assign bus.c_wreq      = c_wreq_q;
  assign bus.c_addr      = c_addr_q;
  assign bus.c_burst     = c_burst_q;
  assign bus.timeout_err = terr_q;
endmodule
